fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 83 ++++++++
 rtl/fetch_buffer.sv | 145 ++++++++++++++
 tb/tb_fetch_buffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch buffer.
//   XLEN          : address / instruction word width
//   DEPTH_DEFAULT : default number of instruction FIFO entries
//   fetch_state_t : request FSM states (IDLE, WAIT, DISCARD)
//   fetch_entry_t : one FIFO entry {pc, data, fault}
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int XLEN          = 32;
    localparam int DEPTH_DEFAULT = 4;

    // IDLE    : no memory request outstanding
    // WAIT    : one request outstanding, its response will be kept
    // DISCARD : one request outstanding, its response will be dropped
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
        logic            fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Instruction FIFO of fetch_entry_t with up to two writes per cycle.
// The second write port exists because a memory response and a misaligned
// PC (which becomes a fault entry without touching memory) can both land in
// the same cycle; the primary port is always the older of the two.
//   clk, reset              : clock, asynchronous active-high reset
//   clear                   : empty the FIFO; overrides any push/pop
//   push, push_entry        : primary (older) write
//   push_extra, push_extra_entry : secondary (younger) write
//   pop                     : remove head entry (ignored when empty)
//   count                   : number of valid entries, 0..DEPTH
//   head                    : entry at the read pointer
// ---------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     push_extra,
    input  fetch_entry_t             push_extra_entry,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            pop_ok;
    logic            push_ok;
    logic            extra_ok;
    logic [CW-1:0]   space;

    // A pop frees its slot in the same cycle, so a push into a full FIFO
    // alongside a pop is allowed; any write that would overflow is dropped.
    always_comb begin
        pop_ok   = pop && (count != '0);
        space    = CW'(DEPTH) - count + CW'(pop_ok);
        push_ok  = push && (space != '0);
        extra_ok = push_extra && (space > CW'(push_ok));
    end

    // Pointers are PW bits wide, so wrapping modulo DEPTH is free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop_ok);
            wr_ptr <= wr_ptr + PW'(push_ok) + PW'(extra_ok);
            count  <= count + CW'(push_ok) + CW'(extra_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (push_ok) begin
                mem[wr_ptr] <= push_entry;
            end
            if (extra_ok) begin
                mem[wr_ptr + PW'(push_ok)] <= push_extra_entry;
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// Accepts fetch addresses from the PC, issues at most one instruction memory
// request at a time, and queues returned instructions (or misaligned-fetch
// faults) for decode. A flush discards queued work and drops the response of
// any request still in flight.
//   clk, reset              : clock, asynchronous active-high reset
//   pc_in, pc_valid         : fetch address offered by the PC
//   pc_ready                : fetch address accepted this cycle
//   flush                   : branch redirect
//   imem_req, imem_addr     : registered memory request
//   imem_ack, imem_rdata    : memory response
//   inst_valid, inst_ready  : decode handshake on the FIFO head
//   inst_data, inst_pc, inst_fault : head entry contents
// XLEN must match fetch_pkg::XLEN, which sizes the stored entries.
// ---------------------------------------------------------------------------
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int XLEN  = fetch_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    input  logic            pc_valid,
    output logic            pc_ready,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic            req_next;
    logic [XLEN-1:0] addr_next;
    logic [CW-1:0]   count;
    logic [CW-1:0]   occupied;
    logic            accept;
    logic            aligned;
    logic            push_ack;
    logic            push_fault;
    logic            pop;
    fetch_entry_t    ack_entry;
    fetch_entry_t    fault_entry;
    fetch_entry_t    head;

    // State and request registers; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            state     <= state_next;
            imem_req  <= req_next;
            imem_addr <= addr_next;
        end
    end

    // An outstanding WAIT request reserves a FIFO slot for its response, so
    // occupancy counts it. A new PC is taken only when nothing is in flight
    // or the in-flight request completes this cycle, keeping at most one
    // request outstanding while allowing back-to-back single-cycle fetches.
    always_comb begin
        occupied    = count + CW'(state == WAIT);
        pc_ready    = !reset && !flush && (state != DISCARD) &&
                      (occupied < CW'(DEPTH)) && ((state == IDLE) || imem_ack);
        accept      = pc_valid && pc_ready;
        aligned     = (pc_in[1:0] == 2'b00);
        push_ack    = (state == WAIT) && imem_ack && !flush;
        push_fault  = accept && !aligned;
        pop         = inst_valid && inst_ready;
        ack_entry   = '{pc: imem_addr, data: imem_rdata, fault: 1'b0};
        fault_entry = '{pc: pc_in, data: '0, fault: 1'b1};

        state_next  = state;
        req_next    = imem_req;
        addr_next   = imem_addr;

        case (state)
            IDLE: begin
                if (accept && aligned) begin
                    state_next = WAIT;
                    req_next   = 1'b1;
                    addr_next  = pc_in;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    if (accept && aligned) begin
                        state_next = WAIT;
                        req_next   = 1'b1;
                        addr_next  = pc_in;
                    end else begin
                        state_next = IDLE;
                        req_next   = 1'b0;
                    end
                end else if (flush) begin
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_ack) begin
                    state_next = IDLE;
                    req_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk              (clk),
        .reset            (reset),
        .clear            (flush),
        .push             (push_ack),
        .push_entry       (ack_entry),
        .push_extra       (push_fault),
        .push_extra_entry (fault_entry),
        .pop              (pop),
        .count            (count),
        .head             (head)
    );

    assign inst_valid = (count != '0);
    assign inst_data  = head.data;
    assign inst_pc    = head.pc;
    assign inst_fault = head.fault;

endmodule

// File: tb/tb_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_fetch_buffer
// Directed scenarios followed by randomized traffic, checked every cycle
// against a queue-based reference model of the fetch buffer.
// ---------------------------------------------------------------------------
module tb_fetch_buffer;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk;
    logic            reset;
    logic [XLEN-1:0] pc_in;
    logic            pc_valid;
    logic            pc_ready;
    logic            flush;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            inst_fault;

    fetch_buffer #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_data  (inst_data),
        .inst_pc    (inst_pc),
        .inst_fault (inst_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    // Reference model: queued instructions plus one in-flight request.
    exp_t        q[$];
    bit          m_out;
    bit          m_drop;
    logic [31:0] m_addr;
    int          m_age;
    int          m_lat;
    int          lat_sel;
    int          vectors;
    int          miscompares;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic bit expReady();
        int occ;
        occ = q.size() + ((m_out && !m_drop) ? 1 : 0);
        return !flush && !m_drop && (occ < DEPTH) && (!m_out || imem_ack);
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory answers a request once it has been visible for m_lat cycles.
    task automatic applyStimulus(input bit pv, input logic [31:0] pc, input bit rdy, input bit fl);
        pc_valid   = pv;
        pc_in      = pc;
        inst_ready = rdy;
        flush      = fl;
        imem_ack   = m_out && (m_age >= m_lat);
        imem_rdata = m_out ? mem_word(m_addr) : $urandom;
    endtask

    task automatic checkOutput();
        cmp("pc_ready", {31'd0, pc_ready}, {31'd0, expReady()});
        cmp("imem_req", {31'd0, imem_req}, {31'd0, m_out});
        cmp("imem_addr", imem_addr, m_addr);
        cmp("inst_valid", {31'd0, inst_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            cmp("inst_pc", inst_pc, q[0].pc);
            cmp("inst_data", inst_data, q[0].data);
            cmp("inst_fault", {31'd0, inst_fault}, {31'd0, q[0].fault});
        end
    endtask

    task automatic modelStep();
        bit acc;
        bit ack;
        bit fresh;
        acc   = pc_valid && expReady();
        ack   = imem_ack;
        fresh = 1'b0;
        if (flush) begin
            q.delete();
            if (m_out && ack) begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (m_out) begin
                m_drop = 1'b1;
            end
        end else begin
            if ((q.size() != 0) && inst_ready) void'(q.pop_front());
            if (m_out && ack) begin
                if (!m_drop) q.push_back('{pc: m_addr, data: mem_word(m_addr), fault: 1'b0});
                m_out  = 1'b0;
                m_drop = 1'b0;
            end
            if (acc) begin
                if (pc_in[1:0] == 2'b00) begin
                    m_out  = 1'b1;
                    m_addr = pc_in;
                    m_age  = 0;
                    m_lat  = lat_sel;
                    fresh  = 1'b1;
                end else begin
                    q.push_back('{pc: pc_in, data: 32'd0, fault: 1'b1});
                end
            end
        end
        if (m_out && !fresh) m_age++;
    endtask

    task automatic runCycle(input bit pv, input logic [31:0] pc, input bit rdy, input bit fl);
        applyStimulus(pv, pc, rdy, fl);
        #3;
        checkOutput();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    // Reset is raised between edges and its effect checked before any edge.
    task automatic resetDut();
        #2;
        reset    = 1'b1;
        pc_valid = 1'b1;
        pc_in    = 32'h0;
        flush    = 1'b0;
        imem_ack = 1'b0;
        #1;
        cmp("rst_imem_req", {31'd0, imem_req}, 32'd0);
        cmp("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        cmp("rst_pc_ready", {31'd0, pc_ready}, 32'd0);
        cmp("rst_imem_addr", imem_addr, 32'd0);
        q.delete();
        m_out  = 1'b0;
        m_drop = 1'b0;
        m_addr = 32'd0;
        m_age  = 0;
        m_lat  = 0;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        pc_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] pc;
        vectors     = 0;
        miscompares = 0;
        lat_sel     = 0;
        reset       = 1'b1;
        pc_valid    = 1'b0;
        pc_in       = '0;
        flush       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b0;

        resetDut();

        // Sequential fetch with single-cycle memory.
        lat_sel = 0;
        for (int i = 0; i < 5; i++) runCycle(1'b1, 32'(i * 4), 1'b1, 1'b0);
        repeat (3) runCycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Decode stalled: FIFO fills, then one pop frees one slot.
        for (int i = 0; i < 8; i++) runCycle(1'b1, 32'(32'h40 + i * 4), 1'b0, 1'b0);
        runCycle(1'b1, 32'h60, 1'b1, 1'b0);
        repeat (3) runCycle(1'b1, 32'h64, 1'b0, 1'b0);
        repeat (6) runCycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while waiting on 0x20; response arrives three cycles later.
        lat_sel = 3;
        runCycle(1'b1, 32'h20, 1'b1, 1'b0);
        lat_sel = 0;
        runCycle(1'b0, 32'h0, 1'b1, 1'b1);
        repeat (5) runCycle(1'b1, 32'h100, 1'b1, 1'b0);
        repeat (3) runCycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush coinciding with the ack.
        lat_sel = 2;
        runCycle(1'b1, 32'h40, 1'b1, 1'b0);
        repeat (2) runCycle(1'b0, 32'h0, 1'b1, 1'b0);
        runCycle(1'b0, 32'h0, 1'b1, 1'b1);
        repeat (2) runCycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Misaligned fetch becomes a fault entry without a memory request.
        lat_sel = 0;
        runCycle(1'b1, 32'h6, 1'b0, 1'b0);
        runCycle(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) runCycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Reset during an outstanding request, then fetch from 0.
        lat_sel = 5;
        runCycle(1'b1, 32'h80, 1'b1, 1'b0);
        runCycle(1'b0, 32'h0, 1'b1, 1'b0);
        resetDut();
        lat_sel = 0;
        runCycle(1'b1, 32'h0, 1'b1, 1'b0);
        repeat (3) runCycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            lat_sel = $urandom_range(0, 3);
            pc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) pc[1:0] = 2'($urandom_range(1, 3));
            runCycle($urandom_range(0, 9) < 7, pc, $urandom_range(0, 9) < 6,
                     $urandom_range(0, 29) == 0);
        end
        repeat (8) runCycle(1'b0, 32'h0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
